// File: rtl/loader_pkg.sv
//------------------------------------------------------------------------------
// Module   : loader_pkg
// Purpose  : Shared types and constants for the serial program loader.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package loader_pkg;

  localparam int c_addr_w = 8;
  localparam int c_data_w = 8;
  localparam logic [c_data_w-1:0] c_sync_byte = 8'hA5;

  typedef enum logic [2:0] {
    S_HUNT  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_ram.sv
//------------------------------------------------------------------------------
// Module   : instr_ram
// Purpose  : 256x8 instruction RAM, synchronous write, asynchronous read.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_ram
  import loader_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [c_addr_w-1:0] waddr,
  input  logic [c_data_w-1:0] wdata,
  input  logic [c_addr_w-1:0] addr,
  output logic [c_data_w-1:0] data
);

  // Configuration-time contents; reset never touches the array.
  logic [c_data_w-1:0] r_mem [0:(1<<c_addr_w)-1] = '{default: 8'hFF};

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign data = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/program_loader.sv
//------------------------------------------------------------------------------
// Module   : program_loader
// Purpose  : Framed serial loader into instruction RAM; holds the CPU while loading.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module program_loader
  import loader_pkg::*;
#(
  parameter logic [15:0]         TIMEOUT_CYCLES = 16'd50000,
  parameter logic [c_data_w-1:0] SYNC_BYTE      = c_sync_byte
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [c_data_w-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [c_addr_w-1:0] addr,
  output logic [c_data_w-1:0] data,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_err
);

  state_t              r_state;
  logic [8:0]          r_ptr;
  logic [8:0]          r_len;
  logic [7:0]          r_sum;
  logic [15:0]         r_tcnt;
  logic                r_in_ready;
  logic                r_cpu_hold;
  logic                r_load_done;
  logic                r_load_err;

  logic                w_fire;
  logic                w_we;
  logic [8:0]          w_ptr_nxt;
  logic [7:0]          w_csum;
  logic                w_tmo;

  assign w_fire    = in_valid && r_in_ready;
  assign w_we      = w_fire && (r_state == S_DATA);
  assign w_ptr_nxt = r_ptr + 9'd1;
  assign w_csum    = r_sum + in_data;
  assign w_tmo     = (r_tcnt == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_HUNT;
      r_ptr       <= 9'd0;
      r_len       <= 9'd0;
      r_sum       <= 8'd0;
      r_tcnt      <= 16'd0;
      r_in_ready  <= 1'b0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
      r_in_ready  <= 1'b1;
      case (r_state)
        S_HUNT: begin
          r_tcnt <= 16'd0;
          if (w_fire && in_data == SYNC_BYTE) begin
            r_state    <= S_LEN;
            r_cpu_hold <= 1'b1;
          end
        end
        S_LEN, S_DATA, S_CSUM: begin
          // An arriving byte always beats a coincident timeout.
          if (w_fire) begin
            r_tcnt <= 16'd0;
            case (r_state)
              S_LEN: begin
                r_len   <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                r_ptr   <= 9'd0;
                r_sum   <= 8'd0;
                r_state <= S_DATA;
              end
              S_DATA: begin
                r_ptr <= w_ptr_nxt;
                r_sum <= w_csum;
                if (w_ptr_nxt == r_len) begin
                  r_state <= S_CSUM;
                end
              end
              default: begin
                if (w_csum == 8'd0) begin
                  r_load_done <= 1'b1;
                  r_cpu_hold  <= 1'b0;
                end else begin
                  r_load_err  <= 1'b1;
                end
                r_state    <= S_FLUSH;
                r_in_ready <= 1'b0;
              end
            endcase
          end else if (w_tmo) begin
            r_load_err <= 1'b1;
            r_tcnt     <= 16'd0;
            r_state    <= S_HUNT;
          end else begin
            r_tcnt <= r_tcnt + 16'd1;
          end
        end
        S_FLUSH: begin
          r_state <= S_HUNT;
        end
        default: begin
          r_state <= S_HUNT;
        end
      endcase
    end
  end

  instr_ram u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_ptr[7:0]),
    .wdata (in_data),
    .addr  (addr),
    .data  (data)
  );

  assign in_ready  = r_in_ready;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_program_loader
// Purpose  : Directed self-checking bench for program_loader.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] addr = 8'd0;
  logic [7:0] data;
  logic       cpu_hold;
  logic       load_done;
  logic       load_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  program_loader #(
    .TIMEOUT_CYCLES (16'd16),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .addr      (addr),
    .data      (data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always @(negedge clk) begin
    if (load_done) done_cnt++;
    if (load_err)  err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one byte for a single accepted transfer; returns #1 after that edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_wait", 32'(in_ready), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_mem(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    #1;
    chk(tag, 32'(data), 32'(exp));
  endtask

  initial begin
    int good;
    int n;
    logic seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);
    good = 0;
    for (int i = 0; i < 256; i++) begin
      addr = 8'(i);
      #1;
      if (data == 8'hFF) good++;
    end
    chk("init_ff_count", 32'(good), 32'd256);

    // Good 3-byte frame
    send_byte(8'hA5);
    chk("f1_hold_up", 32'(cpu_hold), 32'd1);
    send_byte(8'h03);
    send_byte(8'h11);
    chk_mem("f1_wr_latency", 8'd0, 8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h9A);
    chk("f1_done", 32'(load_done), 32'd1);
    chk("f1_hold_down", 32'(cpu_hold), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("f1_done_cnt", 32'(done_cnt), 32'd1);
    chk_mem("f1_m1", 8'd1, 8'h22);
    chk_mem("f1_m2", 8'd2, 8'h33);
    chk_mem("f1_m3", 8'd3, 8'hFF);

    // Junk in HUNT, then bad checksum
    send_byte(8'h00);
    send_byte(8'h5A);
    chk("hunt_hold", 32'(cpu_hold), 32'd0);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    chk("f2_err", 32'(load_err), 32'd1);
    chk("f2_hold", 32'(cpu_hold), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("f2_err_cnt", 32'(err_cnt), 32'd1);
    chk("f2_done_cnt", 32'(done_cnt), 32'd1);
    chk_mem("f2_m0", 8'd0, 8'h01);
    chk_mem("f2_m1", 8'd1, 8'h02);
    chk_mem("f2_m2", 8'd2, 8'h33);

    // 256-byte frame (LEN=0)
    send_byte(8'hA5);
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i));
    send_byte(8'h80);
    chk("f3_done", 32'(load_done), 32'd1);
    chk("f3_hold", 32'(cpu_hold), 32'd0);
    good = 0;
    for (int i = 0; i < 256; i++) begin
      addr = 8'(i);
      #1;
      if (data == 8'(i)) good++;
    end
    chk("f3_mem_count", 32'(good), 32'd256);
    chk("f3_done_cnt", 32'(done_cnt), 32'd2);

    // Timeout after one payload byte
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'hAA);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (load_err) seen = 1'b1;
    end
    chk("tmo_cycles", 32'(n), 32'd16);
    chk("tmo_hold", 32'(cpu_hold), 32'd1);
    chk_mem("tmo_m0", 8'd0, 8'hAA);
    chk_mem("tmo_m1", 8'd1, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    chk("tmo_err_cnt", 32'(err_cnt), 32'd2);

    // Reset mid-frame, then a clean frame
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h07);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_hold", 32'(cpu_hold), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk_mem("midrst_m0", 8'd0, 8'h07);
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'h7D);
    chk("f4_done", 32'(load_done), 32'd1);
    chk("f4_hold", 32'(cpu_hold), 32'd0);
    chk_mem("f4_m0", 8'd0, 8'hC1);
    chk_mem("f4_m1", 8'd1, 8'hC2);
    chk_mem("f4_m2", 8'd2, 8'h02);
    repeat (2) @(posedge clk);
    #1;
    chk("f4_done_cnt", 32'(done_cnt), 32'd3);
    chk("f4_err_cnt", 32'(err_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_loader.md
# program_loader

Serial program loader and instruction memory for the 8-bit CPU. It accepts a framed byte stream from the UART receiver over a valid/ready handshake and writes the payload into a 256×8 instruction RAM. It holds the CPU while loading, then releases it. The CPU fetch side sees the same combinational 8-bit address / 8-bit data port that a fixed instruction ROM provides, so the CPU core is unchanged.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16'd50000: inter-byte timeout in clk cycles while inside a frame.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- in_data  in  8  received byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- addr  in  8  CPU fetch address.
- data  out  8  instruction at addr; combinational read.
- cpu_hold  out  1  holds the CPU in reset while high.
- load_done  out  1  one-cycle pulse on a good frame.
- load_err  out  1  one-cycle pulse on a checksum error or timeout.

## Operation
- Frame format: SYNC_BYTE, then LEN (0 encodes 256), then LEN payload bytes, then CSUM. A frame is good when the 8-bit sum of the payload plus CSUM, mod 256, equals 0.
- State machine states: HUNT, LEN, DATA, CSUM, FLUSH.
  - HUNT: discards every byte other than SYNC_BYTE. On SYNC_BYTE, go to LEN and set cpu_hold=1.
  - LEN: latch the count (0 becomes 256), clear the write pointer and the sum, go to DATA.
  - DATA: each accepted byte writes mem[ptr], then ptr++ and sum+=byte. After the LENth byte, go to CSUM. Bytes equal to SYNC_BYTE are payload here, not markers.
  - CSUM: on acceptance, if (sum + byte) mod 256 == 0, pulse load_done and clear cpu_hold; otherwise pulse load_err and keep cpu_hold high. Either way go to FLUSH.
  - FLUSH: one cycle with in_ready=0, then return to HUNT.
- Timeout: in LEN, DATA or CSUM, a counter resets on every accepted byte. When it reaches TIMEOUT_CYCLES−1 without a byte, pulse load_err, keep cpu_hold=1 and go to HUNT.
- Memory:
  - Initial contents are 8'hFF at configuration; rst_n does not clear them.
  - Bytes already written by a failed frame stay in memory.
  - A write and a same-cycle read of the same address return the new data the cycle after the write.
- Arithmetic: the pointer is 9 bits, so 256 is reachable for LEN=0. The RAM is indexed by ptr[7:0]. The sum and checksum are 8-bit and wrap.

## Timing
- Reset values: state=HUNT, cpu_hold=0, load_done=0, load_err=0, in_ready=0 while rst_n=0, counters 0. in_ready goes high the first cycle after reset is released.
- in_ready=1 in every state except FLUSH and reset. It does not depend on in_valid.
- Write latency: a byte accepted at edge k is readable at data from edge k+1.
- load_done and load_err assert on the edge after the CSUM byte is accepted, for exactly one cycle. cpu_hold falls on that same edge for a good frame.
- A timeout fires and a byte arrives in the same cycle: the byte wins and the counter resets.
- rst_n asserted mid-frame: the frame is abandoned next edge, cpu_hold returns to 0, and the partial memory contents stay.
- After a good frame, cpu_hold stays 0 until the next SYNC_BYTE seen in HUNT.

## Structure
- Shared package `loader_pkg`: the state enum (HUNT, LEN, DATA, CSUM, FLUSH), the SYNC_BYTE default, and 8-bit address/data width constants shared with the CPU fetch path.
- Sub-module `instr_ram`: 256×8 RAM with a synchronous write port (we, waddr, wdata) and an asynchronous read port (addr→data). It holds the 8'hFF initialisation.
- Top level: the FSM, the 9-bit pointer, the 8-bit sum, the timeout counter, and the output registers.

## Test plan
- Reset, then read addresses 0 through 255 → every read returns 8'hFF; cpu_hold=0; in_ready=1 after release.
- Send A5, 03, 11, 22, 33, CSUM=9A → mem[0..2]=11,22,33; load_done pulses once; cpu_hold goes 1 then 0; mem[3] stays FF.
- Send 00, 5A, then A5, 02, 01, 02, CSUM=00 → the leading bytes are ignored in HUNT; load_err pulses; cpu_hold stays 1; mem[0..1]=01,02.
- Send A5, 00, then 256 bytes with byte i = i, then CSUM=80 → all 256 locations equal their address; load_done pulses (the payload sums to 0x80, and 0x80 + 0x80 = 0 mod 256); the pointer wrap has no side effects.
- With TIMEOUT_CYCLES=16, send A5, 04, AA, then go idle → load_err pulses 16 cycles after the AA byte; state returns to HUNT; cpu_hold=1; mem[0]=AA.
- Assert rst_n=0 in the middle of the DATA phase → cpu_hold=0 the next cycle; a following complete frame loads correctly.
